alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle controller for the 8-bit accumulator ALU. It accepts instructions over a valid/ready handshake,
//  owns the AC register and E flag, and drives the ALU selector and operands.
//  It also runs the looped shift op ASHN and streams AC out over a second handshake.
//  The ALU instance sits beside this block at CPU top level; its combinational result and E feed back in.
// PARAMETERS
//  WIDTH  8  datapath width; must equal the ALU width
//  CNT_W  3  width of the ASHN repeat counter (max 7 shifts)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  instr_valid  in   1      instruction offered
//  instr_ready  out  1      high only in IDLE; accept = valid & ready
//  instr_op     in   3      opcode
//  instr_opnd   in   WIDTH  immediate operand
//  alu_sel      out  3      ALU selector; never driven 3'b111
//  alu_ac       out  WIDTH  ALU AC input (= ac)
//  alu_dr       out  WIDTH  ALU DR input (internal DR register)
//  alu_result   in   WIDTH  ALU result
//  alu_e        in   1      ALU carry/shift-out
//  ac           out  WIDTH  accumulator
//  e_flag       out  1      registered E
//  out_valid    out  1      AC presented on out_data
//  out_data     out  WIDTH  AC snapshot, stable while out_valid
//  out_ready    in   1      consumer accepts
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ac=0, e_flag=0, dr=0, cnt=0, alu_sel=3'b101, out_valid=0, out_data=0.
//  Opcodes (000-110 are passed to alu_sel unchanged):
//   000 ADD   dr<=opnd; ac<=ac+dr;      e<=alu_e
//   001 ASHL  dr<=opnd; ac<=ashl(dr);   e<=alu_e
//   010 XNOR  dr<=opnd; ac<=ac~^dr;     e unchanged
//   011 DIV2  dr<=opnd; ac<=dr>>>1;     e<=alu_e
//   100 LDA   dr<=opnd; ac<=dr;         e unchanged
//   101 OUT   no AC write; present ac on out port
//   110 NEG   dr<=ac (opnd ignored); ac<=-dr (2's complement); e unchanged
//   111 ASHN  dr<=ac; cnt<=opnd[CNT_W-1:0]; shift cnt times; e<=last alu_e
//  FSM: IDLE -> EXEC | OUTP | SHIFT.
//   IDLE: instr_ready=1. On accept, latch op, load dr per table, and go to EXEC (ops 000-100, 110), OUTP (101) or SHIFT (111).
//         ASHN with opnd[CNT_W-1:0]=0 is a no-op: stay in IDLE; ac and e unchanged.
//   EXEC (1 cycle): alu_sel=op; at clock edge ac<=alu_result, e per table -> IDLE. Latency accept->ac update = 2 edges.
//   SHIFT: alu_sel=001. Each cycle dr<=alu_result and cnt<=cnt-1. On the cnt==1 cycle ac<=alu_result, e<=alu_e -> IDLE.
//         Total n+1 cycles from accept.
//   OUTP: out_data<=ac at entry; out_valid=1 until out_valid&out_ready, then IDLE. out_data held stable meanwhile.
//  alu_sel=3'b101 in IDLE/OUTP (ALU otherwise holds previous value on unlisted codes; 111 is forbidden).
//  instr_ready=0 in every non-IDLE state; the next instruction is accepted the cycle after return to IDLE.
//  Reset mid-operation aborts immediately: out_valid drops, ac/e return to 0, partial ASHN result is discarded.
//  All arithmetic is modulo 2^WIDTH; the carry is observed only through alu_e.
// STRUCTURE
//  Shared package alu_ctrl_pkg: opcode localparams (OP_ADD..OP_ASHN), state encoding (IDLE, EXEC, SHIFT, OUTP),
//  ALU_SEL_PASS_AC=3'b101.
//  Single always block for FSM + registers; no sub-module. The ALU is instantiated at CPU top level, not inside.
// TESTING
//  1. LDA C1, ADD A3 -> ac=8'h64, e_flag=1; each ac update exactly 2 edges after accept.
//  2. ASHL B1 -> ac=8'h62, e_flag=1; then LDA B2, XNOR 86 -> ac=8'hCB, e_flag still 1.
//  3. LDA 01, ASHN 3 -> ac=8'h08 on 4th edge after accept, e_flag=0; ASHN 0 -> ac unchanged, instr_ready stays 1.
//  4. LDA 9A, NEG -> ac=8'h66; DIV2 46 -> ac=8'h23, e_flag=0.
//  5. LDA 5A, OUT with out_ready=0 for 5 cycles -> out_valid=1, out_data=5A stable, instr_ready=0; out_ready=1 -> IDLE next edge.
//  6. rst_n low mid-ASHN 7 and mid-OUTP -> immediate ac=0, e_flag=0, out_valid=0, state IDLE; alu_sel never observed as 111.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the accumulator ALU controller: opcodes, FSM states
// and the ALU selector code that simply passes AC through.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ASHL = 3'b001;
  localparam logic [2:0] OP_XNOR = 3'b010;
  localparam logic [2:0] OP_DIV2 = 3'b011;
  localparam logic [2:0] OP_LDA  = 3'b100;
  localparam logic [2:0] OP_OUT  = 3'b101;
  localparam logic [2:0] OP_NEG  = 3'b110;
  localparam logic [2:0] OP_ASHN = 3'b111;

  // Selector used whenever the ALU result is not consumed; keeps the ALU
  // away from the forbidden 3'b111 code.
  localparam logic [2:0] ALU_SEL_PASS_AC = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    OUTP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction and AC-output handshakes of the ALU sequencer. The slave side
// is the sequencer; the master side issues instructions and consumes AC.
interface alu_sequencer_if #(parameter int WIDTH = 8);

  logic             instr_valid;
  logic             instr_ready;
  logic [2:0]       instr_op;
  logic [WIDTH-1:0] instr_opnd;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output instr_valid, instr_op, instr_opnd, out_ready,
    input  instr_ready, out_valid, out_data
  );

  modport slave (
    input  instr_valid, instr_op, instr_opnd, out_ready,
    output instr_ready, out_valid, out_data
  );

endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the 8-bit accumulator ALU. Owns AC, E and DR,
// steers the external ALU, runs the looped ASHN shift and streams AC out.
module alu_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_ac,
  output logic [WIDTH-1:0] alu_dr,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_e,
  output logic [WIDTH-1:0] ac,
  output logic             e_flag,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic             e_q, e_d;
  logic [WIDTH-1:0] dr_q, dr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  // Register every piece of state; reset aborts whatever is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ac_q       <= '0;
      e_q        <= 1'b0;
      dr_q       <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ac_q       <= ac_d;
      e_q        <= e_d;
      dr_q       <= dr_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      out_data_q <= out_data_d;
    end
  end

  // Next-state and register updates: decode on accept, then one EXEC cycle,
  // a counted run of shifts, or an output handshake before returning to IDLE.
  always_comb begin
    state_d    = state_q;
    ac_d       = ac_q;
    e_d        = e_q;
    dr_d       = dr_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    out_data_d = out_data_q;

    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          op_d = bus.instr_op;
          if (bus.instr_op == OP_ASHN) begin
            if (bus.instr_opnd[CNT_W-1:0] != '0) begin
              dr_d    = ac_q;
              cnt_d   = bus.instr_opnd[CNT_W-1:0];
              state_d = SHIFT;
            end
          end else if (bus.instr_op == OP_OUT) begin
            out_data_d = ac_q;
            state_d    = OUTP;
          end else if (bus.instr_op == OP_NEG) begin
            dr_d    = ac_q;
            state_d = EXEC;
          end else begin
            dr_d    = bus.instr_opnd;
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        ac_d    = alu_result;
        state_d = IDLE;
        case (op_q)
          OP_ADD, OP_ASHL, OP_DIV2: e_d = alu_e;
          OP_XNOR, OP_LDA, OP_NEG:  e_d = e_q;
          default:                  e_d = e_q;
        endcase
      end

      SHIFT: begin
        dr_d  = alu_result;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          ac_d    = alu_result;
          e_d     = alu_e;
          state_d = IDLE;
        end
      end

      OUTP: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ALU selector: only EXEC and SHIFT use the result; everything else parks
  // the ALU on the AC pass-through code.
  always_comb begin
    alu_sel = ALU_SEL_PASS_AC;
    case (state_q)
      EXEC:    alu_sel = op_q;
      SHIFT:   alu_sel = OP_ASHL;
      default: alu_sel = ALU_SEL_PASS_AC;
    endcase
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.out_valid   = (state_q == OUTP);
  assign bus.out_data    = out_data_q;
  assign busy            = (state_q != IDLE);
  assign alu_ac          = ac_q;
  assign alu_dr          = dr_q;
  assign ac              = ac_q;
  assign e_flag          = e_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer, with a behavioural model
// of the accumulator ALU closing the loop.
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic [2:0] alu_sel;
  logic [7:0] alu_ac;
  logic [7:0] alu_dr;
  logic [7:0] alu_result;
  logic       alu_e;
  logic [7:0] ac;
  logic       e_flag;
  logic       busy;

  int total = 0;
  int bad   = 0;
  bit sel111Seen = 1'b0;

  alu_sequencer_if #(.WIDTH(8)) bus ();

  alu_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .alu_sel    (alu_sel),
    .alu_ac     (alu_ac),
    .alu_dr     (alu_dr),
    .alu_result (alu_result),
    .alu_e      (alu_e),
    .ac         (ac),
    .e_flag     (e_flag),
    .busy       (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: result and carry/shift-out for each selector code.
  always_comb begin
    alu_result = 8'h00;
    alu_e      = 1'b0;
    case (alu_sel)
      3'b000: {alu_e, alu_result} = {1'b0, alu_ac} + {1'b0, alu_dr};
      3'b001: begin alu_result = {alu_dr[6:0], 1'b0}; alu_e = alu_dr[7]; end
      3'b010: alu_result = alu_ac ~^ alu_dr;
      3'b011: begin alu_result = {alu_dr[7], alu_dr[7:1]}; alu_e = alu_dr[0]; end
      3'b100: alu_result = alu_dr;
      3'b101: alu_result = alu_ac;
      3'b110: alu_result = 8'h00 - alu_dr;
      default: begin alu_result = 8'hxx; alu_e = 1'bx; end
    endcase
  end

  // Remember if the forbidden selector code ever shows up.
  always @(negedge clk) begin
    if (alu_sel === 3'b111) sel111Seen = 1'b1;
  end

  // Hard stop in case the sequence itself wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Wait (bounded) for instr_ready, offer one instruction, leave just after the accept edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] opnd);
    int waitCycles = 0;
    @(negedge clk);
    while (bus.instr_ready !== 1'b1 && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("ready_wait", 16'(waitCycles < 50), 16'd1);
    bus.instr_valid = 1'b1;
    bus.instr_op    = op;
    bus.instr_opnd  = opnd;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
  endtask

  // Single-cycle EXEC op: AC must still hold the old value one edge after accept, new value after two.
  task automatic runExec(input string tag, input logic [2:0] op, input logic [7:0] opnd,
                         input logic [7:0] oldAc, input logic [7:0] expAc, input logic expE);
    applyStimulus(op, opnd);
    @(negedge clk);
    checkOutput({tag, "_ac_hold"}, 16'(ac), 16'(oldAc));
    checkOutput({tag, "_busy"}, 16'(busy), 16'd1);
    @(negedge clk);
    checkOutput({tag, "_ac"}, 16'(ac), 16'(expAc));
    checkOutput({tag, "_e"}, 16'(e_flag), 16'(expE));
    checkOutput({tag, "_ready"}, 16'(bus.instr_ready), 16'd1);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_op    = 3'b000;
    bus.instr_opnd  = 8'h00;
    bus.out_ready   = 1'b0;
    rst_n           = 1'b0;
    #3;
    checkOutput("rst_ac", 16'(ac), 16'h00);
    checkOutput("rst_e", 16'(e_flag), 16'h0);
    checkOutput("rst_dr", 16'(alu_dr), 16'h00);
    checkOutput("rst_sel", 16'(alu_sel), 16'h5);
    checkOutput("rst_out_valid", 16'(bus.out_valid), 16'h0);
    checkOutput("rst_out_data", 16'(bus.out_data), 16'h00);
    checkOutput("rst_ready", 16'(bus.instr_ready), 16'h1);
    checkOutput("rst_busy", 16'(busy), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] LDA/ADD with carry");
    runExec("lda_c1", 3'b100, 8'hC1, 8'h00, 8'hC1, 1'b0);
    checkOutput("lda_c1_dr", 16'(alu_dr), 16'hC1);
    runExec("add_a3", 3'b000, 8'hA3, 8'hC1, 8'h64, 1'b1);

    $display("[TB] ASHL then XNOR keeps E");
    runExec("ashl_b1", 3'b001, 8'hB1, 8'h64, 8'h62, 1'b1);
    runExec("lda_b2", 3'b100, 8'hB2, 8'h62, 8'hB2, 1'b1);
    runExec("xnor_86", 3'b010, 8'h86, 8'hB2, 8'hCB, 1'b1);

    $display("[TB] ASHN looped shift");
    runExec("lda_01", 3'b100, 8'h01, 8'hCB, 8'h01, 1'b1);
    applyStimulus(3'b111, 8'h03);
    @(negedge clk);
    checkOutput("ashn3_sel", 16'(alu_sel), 16'h1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ashn3_ac_edge3", 16'(ac), 16'h01);
    checkOutput("ashn3_busy_edge3", 16'(busy), 16'h1);
    @(negedge clk);
    checkOutput("ashn3_ac_edge4", 16'(ac), 16'h08);
    checkOutput("ashn3_e", 16'(e_flag), 16'h0);
    checkOutput("ashn3_ready", 16'(bus.instr_ready), 16'h1);
    applyStimulus(3'b111, 8'h00);
    @(negedge clk);
    checkOutput("ashn0_ready", 16'(bus.instr_ready), 16'h1);
    checkOutput("ashn0_busy", 16'(busy), 16'h0);
    checkOutput("ashn0_ac", 16'(ac), 16'h08);
    checkOutput("ashn0_e", 16'(e_flag), 16'h0);

    $display("[TB] NEG and DIV2");
    runExec("lda_9a", 3'b100, 8'h9A, 8'h08, 8'h9A, 1'b0);
    runExec("neg", 3'b110, 8'hFF, 8'h9A, 8'h66, 1'b0);
    checkOutput("neg_dr", 16'(alu_dr), 16'h9A);
    runExec("div2_46", 3'b011, 8'h46, 8'h66, 8'h23, 1'b0);

    $display("[TB] OUT with back-pressure");
    runExec("lda_5a", 3'b100, 8'h5A, 8'h23, 8'h5A, 1'b0);
    applyStimulus(3'b101, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("out_valid_stall", 16'(bus.out_valid), 16'h1);
      checkOutput("out_data_stall", 16'(bus.out_data), 16'h5A);
      checkOutput("out_ready_low", 16'(bus.instr_ready), 16'h0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("out_done_valid", 16'(bus.out_valid), 16'h0);
    checkOutput("out_done_ready", 16'(bus.instr_ready), 16'h1);
    checkOutput("out_ac_kept", 16'(ac), 16'h5A);

    $display("[TB] reset mid-ASHN and mid-OUTP");
    runExec("lda_3c", 3'b100, 8'h3C, 8'h5A, 8'h3C, 1'b0);
    runExec("add_ff", 3'b000, 8'hFF, 8'h3C, 8'h3B, 1'b1);
    applyStimulus(3'b111, 8'h07);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_ashn_ac", 16'(ac), 16'h00);
    checkOutput("rst_ashn_e", 16'(e_flag), 16'h0);
    checkOutput("rst_ashn_busy", 16'(busy), 16'h0);
    checkOutput("rst_ashn_sel", 16'(alu_sel), 16'h5);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) @(negedge clk);
    checkOutput("rst_ashn_discard", 16'(ac), 16'h00);
    runExec("lda_77", 3'b100, 8'h77, 8'h00, 8'h77, 1'b0);
    applyStimulus(3'b101, 8'h00);
    @(negedge clk);
    checkOutput("outp_pre_rst_valid", 16'(bus.out_valid), 16'h1);
    checkOutput("outp_pre_rst_data", 16'(bus.out_data), 16'h77);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_outp_valid", 16'(bus.out_valid), 16'h0);
    checkOutput("rst_outp_data", 16'(bus.out_data), 16'h00);
    checkOutput("rst_outp_ac", 16'(ac), 16'h00);
    checkOutput("rst_outp_ready", 16'(bus.instr_ready), 16'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("alu_sel_never_111", 16'(sel111Seen), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
